// File: rtl/tc_sram_rr_arb_pkg.sv
// Shared types for the round-robin SRAM arbiter: requester index and response-pipe metadata.
package tc_sram_rr_arb_pkg;

  // Wide enough for the largest supported requester count (16).
  localparam int unsigned MaxIdxW = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  typedef logic [MaxIdxW-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } rsp_meta_t;

endpackage

// File: rtl/tc_sram_rr_arb_rsp_pipe.sv
// Latency-deep shift register carrying read-response tags alongside the SRAM access.
module tc_sram_rr_arb_rsp_pipe
  import tc_sram_rr_arb_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  rsp_meta_t meta_i,
  output rsp_meta_t meta_o
);

  rsp_meta_t r_stage [Latency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Latency); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= meta_i;
      for (int i = 1; i < int'(Latency); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign meta_o = r_stage[Latency-1];

endmodule

// File: rtl/tc_sram_rr_arb.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Optional grant locking is enabled by defining TC_SRAM_RR_ARB_LOCK_EN.
module tc_sram_rr_arb
  import tc_sram_rr_arb_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumReq-1:0]                       req_valid_i,
  output logic [NumReq-1:0]                       req_ready_o,
  input  logic [NumReq-1:0]                       req_we_i,
  input  logic [NumReq*AddrWidth-1:0]             req_addr_i,
  input  logic [NumReq*DataWidth-1:0]             req_wdata_i,
  input  logic [NumReq*(DataWidth/ByteWidth)-1:0] req_be_i,
`ifdef TC_SRAM_RR_ARB_LOCK_EN
  input  logic [NumReq-1:0]                       req_lock_i,
`endif
  output logic [NumReq-1:0]                       rsp_valid_o,
  output logic [DataWidth-1:0]                    rsp_rdata_o,
  output logic                                    sram_req_o,
  output logic                                    sram_we_o,
  output logic [AddrWidth-1:0]                    sram_addr_o,
  output logic [DataWidth-1:0]                    sram_wdata_o,
  output logic [DataWidth/ByteWidth-1:0]          sram_be_o,
  input  logic [DataWidth-1:0]                    sram_rdata_i
);

  localparam int unsigned BeW  = DataWidth / ByteWidth;
  localparam int unsigned IdxW = idx_width(NumReq);

  logic [IdxW-1:0]   r_ptr;
  logic [NumReq-1:0] w_elig;
  logic              w_gnt_vld;
  logic [IdxW-1:0]   w_gnt_idx;
  logic [IdxW-1:0]   w_cand;
  rsp_meta_t         w_push;
  rsp_meta_t         w_pop;

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NumReq) s = s - NumReq;
    return s[IdxW-1:0];
  endfunction

`ifdef TC_SRAM_RR_ARB_LOCK_EN
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_gnt_vld) begin
      r_lock     <= req_lock_i[w_gnt_idx];
      r_lock_idx <= w_gnt_idx;
    end
  end
`endif

  // Eligibility: locked owner only, and nobody while reset is held.
  always_comb begin
    w_elig = req_valid_i;
`ifdef TC_SRAM_RR_ARB_LOCK_EN
    if (r_lock) w_elig = req_valid_i & (NumReq'(1) << r_lock_idx);
`endif
    if (rst_i) w_elig = '0;
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_cand = wrap_add(r_ptr, k);
      if (!w_gnt_vld && w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    req_ready_o  = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (w_gnt_vld) begin
      req_ready_o[w_gnt_idx] = 1'b1;
      sram_req_o   = 1'b1;
      sram_we_o    = req_we_i[w_gnt_idx];
      sram_addr_o  = req_addr_i[w_gnt_idx*AddrWidth +: AddrWidth];
      sram_wdata_o = req_wdata_i[w_gnt_idx*DataWidth +: DataWidth];
      sram_be_o    = req_be_i[w_gnt_idx*BeW +: BeW];
    end
  end

  // A locking handshake keeps the pointer on the owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
`ifdef TC_SRAM_RR_ARB_LOCK_EN
      if (!req_lock_i[w_gnt_idx]) r_ptr <= wrap_add(w_gnt_idx, 1);
`else
      r_ptr <= wrap_add(w_gnt_idx, 1);
`endif
    end
  end

  always_comb begin
    w_push.valid = w_gnt_vld & ~req_we_i[w_gnt_idx];
    w_push.idx   = idx_t'(w_gnt_idx);
  end

  tc_sram_rr_arb_rsp_pipe #(
    .Latency (Latency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .meta_i (w_push),
    .meta_o (w_pop)
  );

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (w_pop.valid && !rst_i) begin
      rsp_rdata_o = sram_rdata_i;
      for (int unsigned i = 0; i < NumReq; i++)
        rsp_valid_o[i] = (w_pop.idx == idx_t'(i));
    end
  end

endmodule

// File: tb/tb_tc_sram_rr_arb.sv
// Self-checking bench for tc_sram_rr_arb with a behavioural SRAM and reference model.
module tb_tc_sram_rr_arb;
  localparam int N = 4, NW = 1024, DW = 32, BW = 8, LAT = 1, AW = 10, BEW = DW / BW;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*BEW-1:0]  req_be;
  logic [DW-1:0]     rsp_rdata, sram_wdata, sram_rdata;
  logic              sram_req, sram_we;
  logic [AW-1:0]     sram_addr;
  logic [BEW-1:0]    sram_be;
  logic [N-1:0]      req_lock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tc_sram_rr_arb #(
    .NumReq(N), .NumWords(NW), .DataWidth(DW), .ByteWidth(BW), .Latency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
`ifdef TC_SRAM_RR_ARB_LOCK_EN
    .req_lock_i(req_lock),
`endif
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Behavioural single-port SRAM, latency 1, words start at a known preload pattern.
  function automatic logic [DW-1:0] preload(int a);
    return DW'(32'hA5A5_0000 ^ (a * 32'h0001_0003));
  endfunction

  logic [DW-1:0] mem [NW];
  logic [NW-1:0] written;
  logic          sram_clr;
  logic [DW-1:0] sram_nv;

  always @(posedge clk) begin
    if (sram_clr) written <= '0;
    else if (sram_req) begin
      if (sram_we) begin
        sram_nv = written[sram_addr] ? mem[sram_addr] : preload(int'(sram_addr));
        for (int b = 0; b < BEW; b++) if (sram_be[b]) sram_nv[b*BW +: BW] = sram_wdata[b*BW +: BW];
        mem[sram_addr]     <= sram_nv;
        written[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= written[sram_addr] ? mem[sram_addr] : preload(int'(sram_addr));
      end
    end
  end

  // Reference model: pointer, lock owner, shadow memory, expected responses.
  typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
  int            m_ptr, m_lock_idx;
  bit            m_lock;
  rsp_t          m_q[$];
  logic [DW-1:0] m_mem [int];

  function automatic logic [DW-1:0] m_read(int a);
    if (m_mem.exists(a)) return m_mem[a];
    return preload(a);
  endfunction

  function automatic int model_grant(logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (v[j] && (!m_lock || j == m_lock_idx)) return j;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_i = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk); rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1; req_valid = '1; req_we = '1; req_addr = '1; req_wdata = '1; req_be = '1;
    #1;
    n_tests++;
    if ({req_ready, sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got rdy=%b req=%b we=%b addr=%h wd=%h be=%h required all 0",
                         req_ready, sram_req, sram_we, sram_addr, sram_wdata, sram_be);
    end
    n_tests++;
    if ({rsp_valid, rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rsp got v=%b d=%h required 0", rsp_valid, rsp_rdata);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk); rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({sram_req, req_ready, rsp_valid, rsp_rdata} !== '0) begin
        n_fail++; $display("FAIL idle_after_reset c=%0d got req=%b rdy=%b rv=%b rd=%h required 0",
                           c, sram_req, req_ready, rsp_valid, rsp_rdata);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16 + i);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); req_valid = '1; #1;
      n_tests++;
      if (req_ready !== N'(1 << (c % N))) begin
        n_fail++; $display("FAIL rr_grant c=%0d got %b required %b", c, req_ready, N'(1 << (c % N)));
      end
      n_tests++;
      if (c == 0) begin
        if (rsp_valid !== '0) begin
          n_fail++; $display("FAIL rr_first_rsp got %b required 0", rsp_valid);
        end
      end else if (rsp_valid !== N'(1 << ((c - 1) % N)) || rsp_rdata !== preload(16 + (c - 1) % N)) begin
        n_fail++; $display("FAIL rr_rsp c=%0d got v=%b d=%h required v=%b d=%h", c, rsp_valid, rsp_rdata,
                           N'(1 << ((c - 1) % N)), preload(16 + (c - 1) % N));
      end
    end
    @(negedge clk); req_valid = '0; #1;
    n_tests++;
    if (rsp_valid !== 4'b1000 || rsp_rdata !== preload(19)) begin
      n_fail++; $display("FAIL rr_last_rsp got v=%b d=%h required v=1000 d=%h", rsp_valid, rsp_rdata, preload(19));
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_d;
    exp_d = {preload(5)[31:16], 16'hBEEF};
    @(negedge clk); idle_inputs();
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2*AW +: AW] = AW'(5);
    req_wdata[2*DW +: DW] = 32'hDEAD_BEEF; req_be[2*BEW +: BEW] = 4'b0011;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100 || {sram_req, sram_we, sram_addr, sram_be} !== {2'b11, AW'(5), 4'b0011}) begin
      n_fail++; $display("FAIL wr_drive got rdy=%b req=%b we=%b addr=%0d be=%b required 0100 1 1 5 0011",
                         req_ready, sram_req, sram_we, sram_addr, sram_be);
    end
    @(negedge clk); idle_inputs();
    req_valid[0] = 1'b1; req_addr[0 +: AW] = AW'(5);
    #1;
    n_tests++;
    if (req_ready !== 4'b0001 || rsp_valid !== '0) begin
      n_fail++; $display("FAIL wr_no_rsp got rdy=%b rv=%b required rdy=0001 rv=0000", req_ready, rsp_valid);
    end
    @(negedge clk); idle_inputs(); #1;
    n_tests++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== exp_d) begin
      n_fail++; $display("FAIL wr_readback got v=%b d=%h required v=0001 d=%h", rsp_valid, rsp_rdata, exp_d);
    end
  endtask

  task automatic test_lone_requester();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle_inputs(); req_valid[3] = 1'b1; #1;
      n_tests++;
      if (req_ready !== 4'b1000) begin
        n_fail++; $display("FAIL lone_grant c=%0d got %b required 1000", c, req_ready);
      end
    end
    @(negedge clk); req_valid = '1; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL lone_wrap got %b required 0001", req_ready);
    end
  endtask

  task automatic test_reset_drops_read();
    @(negedge clk); idle_inputs(); req_valid[1] = 1'b1; req_addr[AW +: AW] = AW'(16); #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL drop_grant got %b required 0010", req_ready);
    end
    @(negedge clk); idle_inputs(); rst_i = 1'b1; #1;
    n_tests++;
    if (rsp_valid !== '0 || rsp_rdata !== '0) begin
      n_fail++; $display("FAIL drop_in_reset got v=%b d=%h required 0", rsp_valid, rsp_rdata);
    end
    @(negedge clk); rst_i = 1'b0; #1;
    n_tests++;
    if (rsp_valid !== '0) begin
      n_fail++; $display("FAIL drop_after_reset got %b required 0", rsp_valid);
    end
    @(negedge clk); req_valid = '1; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL drop_ptr got %b required 0001", req_ready);
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] tv [7] = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0101};
    logic [N-1:0] tl [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] te [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); req_valid = tv[c]; req_lock = tl[c]; #1;
      n_tests++;
      if (req_ready !== te[c]) begin
        n_fail++; $display("FAIL lock_grant c=%0d got %b required %b", c, req_ready, te[c]);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random(int ncyc);
    int g, hs_g, a;
    logic [N-1:0]  exp_rdy, exp_rv;
    logic [DW-1:0] exp_rd, nv;
    logic [1+1+AW+DW+BEW-1:0] exp_bus;
    rsp_t e;
    do_reset();
    m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_q.delete();
    hs_g = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (hs_g >= 0) req_valid[hs_g] = 1'b0;
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
          req_valid[r] = 1'b1;
          req_we[r]    = ($urandom_range(0, 2) == 0);
          req_addr[r*AW +: AW]    = AW'(32'h100 + $urandom_range(0, 15));
          req_wdata[r*DW +: DW]   = $urandom();
          req_be[r*BEW +: BEW]    = BEW'($urandom_range(1, 15));
`ifdef TC_SRAM_RR_ARB_LOCK_EN
          req_lock[r] = ($urandom_range(0, 3) == 0);
`endif
        end
      end
      #1;
      g = model_grant(req_valid);
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      exp_bus = '0;
      if (g >= 0) exp_bus = {1'b1, req_we[g], req_addr[g*AW +: AW], req_wdata[g*DW +: DW], req_be[g*BEW +: BEW]};
      exp_rv = '0; exp_rd = '0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        e = m_q.pop_front();
        exp_rv[e.idx] = 1'b1; exp_rd = e.data;
      end
      n_tests++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got %b required %b", cyc, req_ready, exp_rdy);
      end
      n_tests++;
      if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== exp_bus) begin
        n_fail++; $display("FAIL rand_sram cyc=%0d got %h required %h", cyc,
                           {sram_req, sram_we, sram_addr, sram_wdata, sram_be}, exp_bus);
      end
      n_tests++;
      if (rsp_valid !== exp_rv || rsp_rdata !== exp_rd) begin
        n_fail++; $display("FAIL rand_rsp cyc=%0d got v=%b d=%h required v=%b d=%h", cyc,
                           rsp_valid, rsp_rdata, exp_rv, exp_rd);
      end
      hs_g = g;
      if (g >= 0) begin
        a = int'(req_addr[g*AW +: AW]);
        if (req_we[g]) begin
          nv = m_read(a);
          for (int b = 0; b < BEW; b++) if (req_be[g*BEW + b]) nv[b*BW +: BW] = req_wdata[g*DW + b*BW +: BW];
          m_mem[a] = nv;
        end else begin
          m_q.push_back('{due: cyc + LAT, idx: g, data: m_read(a)});
        end
`ifdef TC_SRAM_RR_ARB_LOCK_EN
        m_lock = req_lock[g];
        m_lock_idx = g;
        if (!req_lock[g]) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    sram_clr = 1'b1; rst_i = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk); sram_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lone_requester();
    test_reset_drops_read();
`ifdef TC_SRAM_RR_ARB_LOCK_EN
    test_lock();
`endif
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
